// File: rtl/serial_to_parallel_rx_if.sv
// Bundle between serial_to_parallel_rx and its environment: serial input side plus the
// valid/ready word output. The master drives the bitstream and ready; the slave is the receiver.
interface serial_to_parallel_rx_if #(
    parameter int W = 4
);
    localparam int CW = $clog2(W + 1);

    logic          serial_i;
    logic          valid_i;
    logic          flush_i;
    logic [W-1:0]  parallel_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          overrun_o;
    logic [CW-1:0] bit_count_o;
    logic          parity_err_o;

    modport master (
        output serial_i, valid_i, flush_i, out_ready_i,
        input  parallel_o, out_valid_o, overrun_o, bit_count_o, parity_err_o
    );

    modport slave (
        input  serial_i, valid_i, flush_i, out_ready_i,
        output parallel_o, out_valid_o, overrun_o, bit_count_o, parity_err_o
    );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Reassembles MSB-first serial bits into W-bit words behind a valid/ready output register.
// Define SERIAL_RX_PARITY_EN to expect one trailing even-parity bit per word.
module serial_to_parallel_rx #(
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_to_parallel_rx_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  parallel_q, parallel_d;
    logic          out_valid_q, out_valid_d;
    logic          overrun_q, overrun_d;
    logic [W-1:0]  shifted;
    logic [W-1:0]  word;
    logic          complete;
    logic          out_free;
    logic          accept;
`ifdef SERIAL_RX_PARITY_EN
    logic          perr_q, perr_d;
    logic          word_perr;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        shifted     = {shift_q[W-2:0], bus.serial_i};
        word        = shifted;
        complete    = 1'b0;
        accept      = out_valid_q && bus.out_ready_i;
        out_free    = !out_valid_q || bus.out_ready_i;
        out_valid_d = out_valid_q && !bus.out_ready_i;
        parallel_d  = parallel_q;
        overrun_d   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        word_perr   = 1'b0;
        perr_d      = perr_q && !accept;
`endif

        // Flush wins over a bit presented in the same cycle, including a completing one.
        if (bus.flush_i) begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
        end else if (bus.valid_i) begin
            case (state_q)
                IDLE, DATA: begin
                    shift_d = shifted;
                    if (cnt_q == CW'(W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
                        cnt_d   = CW'(W);
`else
                        complete = 1'b1;
                        state_d  = IDLE;
                        shift_d  = '0;
                        cnt_d    = '0;
`endif
                    end else begin
                        state_d = DATA;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    complete  = 1'b1;
                    word      = shift_q;
                    word_perr = ^{shift_q, bus.serial_i};
                    state_d   = IDLE;
                    shift_d   = '0;
                    cnt_d     = '0;
                end
`endif
                default: begin
                    state_d = IDLE;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        if (complete) begin
            if (out_free) begin
                parallel_d  = word;
                out_valid_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                perr_d      = word_perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            parallel_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            parallel_q  <= parallel_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end
    assign bus.parity_err_o = perr_q;
`else
    assign bus.parity_err_o = 1'b0;
`endif

    assign bus.parallel_o  = parallel_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.overrun_o   = overrun_q;
    assign bus.bit_count_o = cnt_q;
endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Downstream companion of the team's 4-bit parallel-to-serial stage.
- Consumes that stage's serial_o/valid_o bitstream, MSB first, and reassembles W-bit words.
- Presents each word to the next consumer through a valid/ready output register, flagging overrun when a completed word cannot be stored.

Parameters:
W, 4, data word width in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
serial_i  input  1  serial data bit, MSB of word first
valid_i  input  1  serial_i carries a data bit this cycle; bits with valid_i=0 are ignored (gaps allowed)
flush_i  input  1  synchronous discard of any partially assembled word
parallel_o  output  W  assembled word, held stable while out_valid_o=1
out_valid_o  output  1  parallel_o holds an unconsumed word
out_ready_i  input  1  consumer accepts the word when out_valid_o && out_ready_i
overrun_o  output  1  one-cycle pulse: a completed word was dropped
bit_count_o  output  $clog2(W+1)  data bits of the current word collected so far
parity_err_o  output  1  parity mismatch for the word in parallel_o (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit count=0, parallel_o=0, out_valid_o=0, overrun_o=0, parity_err_o=0. Reset mid-word discards the partial word and any held output.
- States:
  - IDLE: count=0.
  - DATA: 0<count<W.
  - PARITY: only exists with the macro.
- IDLE → DATA on the first valid bit.
- DATA → IDLE (or → PARITY) on the W-th valid bit.
- PARITY → IDLE on the next valid bit.
- Shift: on each accepted bit, shift_reg <= {shift_reg[W-2:0], serial_i}; count += 1. The first bit received lands in parallel_o[W-1].
- Word completion occurs in the cycle where the final bit (W-th data bit, or the parity bit when enabled) is sampled.
- Output register is "free" this cycle if out_valid_o=0, or if out_valid_o && out_ready_i.
- On completion with the register free:
  - next cycle parallel_o = completed word and out_valid_o = 1.
  - Latency is 1 cycle after the final bit is sampled.
- On completion with the register not free:
  - the new word is dropped.
  - parallel_o/out_valid_o are unchanged.
  - overrun_o=1 for exactly the next cycle.
  - the assembler returns to IDLE.
- Accept without completion: out_valid_o <= 0 next cycle; parallel_o keeps its last value.
- Accept and completion in the same cycle: the new word is loaded and out_valid_o stays 1 with no bubble.
- Back-to-back words (valid_i held high) sustain one word every W cycles (W+1 with parity) with no loss while out_ready_i=1.
- flush_i=1:
  - next cycle count=0, shift_reg=0, state=IDLE.
  - a bit presented in the same cycle is discarded (flush wins over valid_i).
  - the output register, out_valid_o and parity_err_o are unaffected.
  - flush_i in the same cycle as a completing bit suppresses that completion, so no word and no overrun result.
- bit_count_o counts 0..W-1 in DATA, reads W while in PARITY, and returns to 0 after completion.
- The count never exceeds W; no wrap-around beyond a word boundary.

Optional Feature:
- Macro SERIAL_RX_PARITY_EN.
- Defined:
  - each word is followed by one parity bit (even parity: XOR of W data bits and parity bit must be 0).
  - the parity bit is accepted under valid_i like a data bit, in state PARITY.
  - the word is delivered even on mismatch; parity_err_o is loaded together with parallel_o and held with it (cleared on accept without reload).
  - overrun, flush and latency rules apply with the parity bit as the final bit.
- Undefined: no PARITY state; parity_err_o is tied to 0; the frame is W bits.

Test Plan:
- W=4, reset released, bits 1,0,1,1 on consecutive cycles with valid_i=1 and out_ready_i=1 → parallel_o=4'b1011, out_valid_o=1 exactly one cycle after the 4th bit, overrun_o stays 0.
- Bits 0,1 then valid_i=0 for 3 cycles, then 1,0 → bit_count_o holds 2 during the gap; parallel_o=4'b0110.
- out_ready_i=0, send 4'hA then 4'h5 → parallel_o stays 4'hA, overrun_o pulses 1 cycle after the 8th bit; raise out_ready_i → out_valid_o drops next cycle.
- Word 4'h3 held (out_ready_i=0); raise out_ready_i in the cycle the last bit of 4'hC arrives → parallel_o=4'hC, out_valid_o continuously 1, no overrun.
- After 2 bits, flush_i=1 with valid_i=1 → bit_count_o=0 next cycle; the following 4 bits 1,1,0,0 yield 4'hC. Separately, reset driven low mid-word → all outputs 0 immediately, without waiting for a clock edge.
- SERIAL_RX_PARITY_EN: send 1,0,1,1,parity 1 → parallel_o=4'hB, parity_err_o=0; send 1,0,1,1,parity 0 → parity_err_o=1 with out_valid_o.
